// File: rtl/match_merge_tree.sv
// Pipelined binary merge tree selecting the winning rule among subset hits.
// Heap-ordered nodes: one register level per tree depth, root is the output.
module match_merge_tree #(
  parameter int NUM_SUBSET    = 4,
  parameter int INDEX_BIT_LEN = 11,
  parameter int PRIO_MODE     = 0,
  parameter int CNT_WIDTH     = 32,
  localparam int SUB_W = (NUM_SUBSET > 1) ? $clog2(NUM_SUBSET) : 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  input  logic [NUM_SUBSET-1:0]               subset_match,
  input  logic [NUM_SUBSET*INDEX_BIT_LEN-1:0] subset_ruleID,
  input  logic                                flush,
  input  logic                                cnt_clear,
  output logic                                out_valid,
  output logic                                match_reg,
  output logic [INDEX_BIT_LEN-1:0]            matchID_reg,
  output logic [SUB_W-1:0]                    match_subset,
  output logic [CNT_WIDTH-1:0]                hit_cnt,
  output logic [CNT_WIDTH-1:0]                miss_cnt
);

  localparam int LVL = SUB_W;
  localparam int P   = 1 << LVL;

  typedef struct packed {
    logic                     m;
    logic [INDEX_BIT_LEN-1:0] id;
    logic [SUB_W-1:0]         sub;
  } node_t;

  // Left operand always carries the lower subset indices, so ties keep it.
  function automatic node_t pick(input node_t a, input node_t b);
    node_t r;
    logic  b_wins;
    r      = '0;
    b_wins = (PRIO_MODE == 0) ? (b.id > a.id) : (b.id < a.id);
    if (a.m && b.m) r = b_wins ? b : a;
    else if (a.m)   r = a;
    else if (b.m)   r = b;
    return r;
  endfunction

  node_t [P-1:0]   lf;
  node_t [P-2:0]   node_q;
  node_t [P-2:0]   node_d;
  logic  [LVL-1:0] vld_q;
  logic  [LVL-1:0] vld_d;
  logic  [LVL:0]   vchain;

  logic [CNT_WIDTH-1:0] hit_q, hit_d;
  logic [CNT_WIDTH-1:0] miss_q, miss_d;

  for (genvar i = 0; i < P; i++) begin : g_leaf
    if (i < NUM_SUBSET) begin : g_real
      assign lf[i] = {subset_match[i],
                      subset_ruleID[i*INDEX_BIT_LEN +: INDEX_BIT_LEN],
                      SUB_W'(i)};
    end else begin : g_pad
      assign lf[i] = '0;
    end
  end

  // vchain[d+1] is the valid feeding depth d; vchain[0] is the root valid.
  assign vchain = {in_valid, vld_q};
  assign vld_d  = vchain[LVL:1] & ~{LVL{flush}};

  for (genvar k = 0; k < P - 1; k++) begin : g_node
    localparam int DEP = $clog2(k + 2) - 1;
    node_t a, b;
    if (2 * k + 1 >= P - 1) begin : g_from_leaf
      assign a = lf[2*k+1-(P-1)];
      assign b = lf[2*k+2-(P-1)];
    end else begin : g_from_node
      assign a = node_q[2*k+1];
      assign b = node_q[2*k+2];
    end
    assign node_d[k] = vld_d[DEP] ? pick(a, b) : node_q[k];
  end

  always_comb begin
    hit_d  = hit_q;
    miss_d = miss_q;
    if (cnt_clear) begin
      hit_d  = '0;
      miss_d = '0;
    end else if (vld_d[0]) begin
      if (node_d[0].m) begin
        if (~&hit_q) hit_d = hit_q + CNT_WIDTH'(1);
      end else begin
        if (~&miss_q) miss_d = miss_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      node_q <= '0;
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      vld_q  <= vld_d;
      node_q <= node_d;
      hit_q  <= hit_d;
      miss_q <= miss_d;
    end
  end

  assign out_valid    = vchain[0];
  assign match_reg    = node_q[0].m;
  assign matchID_reg  = node_q[0].id;
  assign match_subset = node_q[0].sub;
  assign hit_cnt      = hit_q;
  assign miss_cnt     = miss_q;

endmodule

// File: tb/tb_match_merge_tree.sv
// Scoreboard bench for match_merge_tree: two instances share stimulus,
// one largest-wins with wide counters, one smallest-wins with 2-bit counters.
module tb_match_merge_tree;
  localparam int N   = 4;
  localparam int IBL = 11;

  logic clk = 0;
  logic rst_n = 0;
  logic in_valid = 0;
  logic flush = 0;
  logic cnt_clear = 0;
  logic [N-1:0]     subset_match = '0;
  logic [N*IBL-1:0] subset_ruleID = '0;

  logic ov0, m0;
  logic [IBL-1:0] id0;
  logic [1:0] s0;
  logic [31:0] hit0, miss0;
  logic ov1, m1;
  logic [IBL-1:0] id1;
  logic [1:0] s1;
  logic [1:0] hit1, miss1;

  always #5 clk = ~clk;

  match_merge_tree u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .subset_match(subset_match), .subset_ruleID(subset_ruleID),
    .flush(flush), .cnt_clear(cnt_clear),
    .out_valid(ov0), .match_reg(m0), .matchID_reg(id0),
    .match_subset(s0), .hit_cnt(hit0), .miss_cnt(miss0)
  );

  match_merge_tree #(.PRIO_MODE(1), .CNT_WIDTH(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .subset_match(subset_match), .subset_ruleID(subset_ruleID),
    .flush(flush), .cnt_clear(cnt_clear),
    .out_valid(ov1), .match_reg(m1), .matchID_reg(id1),
    .match_subset(s1), .hit_cnt(hit1), .miss_cnt(miss1)
  );

  typedef struct {
    logic m;
    int   id0, sub0, id1, sub1;
    int   t;
  } exp_t;

  exp_t sb[$];
  exp_t last_e;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int eh0 = 0, em0 = 0, eh1 = 0, em1 = 0;
  logic clr_pend = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_cnts();
    check("hit_cnt0", hit0, eh0);
    check("miss_cnt0", miss0, em0);
    check("hit_cnt1", 32'(hit1), eh1);
    check("miss_cnt1", 32'(miss1), em1);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      clr_pend = 0;
      eh0 = 0; em0 = 0; eh1 = 0; em1 = 0;
      last_e = '{m: 0, id0: 0, sub0: 0, id1: 0, sub1: 0, t: 0};
    end else begin
      if (clr_pend) begin
        eh0 = 0; em0 = 0; eh1 = 0; em1 = 0;
      end
      if (ov0 || ov1) begin
        check("out_valid0", 32'(ov0), 1);
        check("out_valid1", 32'(ov1), 1);
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_out: out_valid with nothing expected (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("latency", cyc - e.t, 2);
          check("match0", 32'(m0), 32'(e.m));
          check("id0", 32'(id0), e.id0);
          check("sub0", 32'(s0), e.sub0);
          check("match1", 32'(m1), 32'(e.m));
          check("id1", 32'(id1), e.id1);
          check("sub1", 32'(s1), e.sub1);
          if (!clr_pend) begin
            if (e.m) begin
              eh0++;
              if (eh1 < 3) eh1++;
            end else begin
              em0++;
              if (em1 < 3) em1++;
            end
          end
          last_e = e;
        end
        check_cnts();
      end else begin
        check("hold0", 32'({m0, id0, s0}),
              32'({last_e.m, IBL'(last_e.id0), 2'(last_e.sub0)}));
        check("hold1", 32'({m1, id1, s1}),
              32'({last_e.m, IBL'(last_e.id1), 2'(last_e.sub1)}));
        if (clr_pend) check_cnts();
      end
      clr_pend = cnt_clear;
    end
  end

  task automatic send(input logic [3:0] mt, input int i0, i1, i2, i3,
                      input logic em, input int e0, es0, e1, es1,
                      input logic fl = 0);
    exp_t e;
    @(posedge clk); #1;
    in_valid      = 1;
    flush         = fl;
    cnt_clear     = 0;
    subset_match  = mt;
    subset_ruleID = {IBL'(i3), IBL'(i2), IBL'(i1), IBL'(i0)};
    if (fl) begin
      sb.delete();
    end else begin
      e.m = em; e.id0 = e0; e.sub0 = es0; e.id1 = e1; e.sub1 = es1; e.t = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n, input logic clr = 0);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid  = 0;
      flush     = 0;
      cnt_clear = clr;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ov0"}, 32'(ov0), 0);
    check({tag, "_out0"}, 32'({m0, id0, s0}), 0);
    check({tag, "_cnt0"}, hit0 | miss0, 0);
    check({tag, "_ov1"}, 32'(ov1), 0);
    check({tag, "_out1"}, 32'({m1, id1, s1}), 0);
    check({tag, "_cnt1"}, 32'({hit1, miss1}), 0);
  endtask

  initial begin
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1;
    idle(2);

    send(4'b0101, 5, 900, 7, 3, 1, 7, 2, 5, 0);
    idle(2);
    send(4'b1011, 12, 12, 12, 12, 1, 12, 0, 12, 0);
    send(4'b1111, 40, 9, 9, 50, 1, 50, 3, 9, 1);
    send(4'b0000, 1, 2, 3, 4, 0, 0, 0, 0, 0);
    idle(3);

    send(4'b0101, 5, 900, 7, 3, 1, 7, 2, 5, 0);
    send(4'b0000, 9, 9, 9, 9, 0, 0, 0, 0, 0);
    send(4'b1000, 1, 2, 3, 300, 1, 300, 3, 300, 3);
    send(4'b0011, 0, 2047, 5, 5, 1, 2047, 1, 0, 0);
    send(4'b0100, 100, 200, 50, 60, 1, 50, 2, 50, 2);
    send(4'b1001, 33, 1, 1, 33, 1, 33, 0, 33, 0);
    idle(4);

    send(4'b0101, 5, 900, 7, 3, 1, 7, 2, 5, 0);
    send(4'b1000, 1, 2, 3, 300, 1, 300, 3, 300, 3, 1);
    idle(3);
    send(4'b0100, 100, 200, 50, 60, 1, 50, 2, 50, 2);
    idle(4);

    send(4'b0101, 5, 900, 7, 3, 1, 7, 2, 5, 0);
    idle(1, 1);
    idle(3);

    repeat (5) send(4'b1000, 1, 2, 3, 300, 1, 300, 3, 300, 3);
    idle(4);

    send(4'b0101, 5, 900, 7, 3, 1, 7, 2, 5, 0);
    send(4'b0000, 9, 9, 9, 9, 0, 0, 0, 0, 0);
    @(posedge clk); #2;
    in_valid = 0;
    rst_n = 0;
    sb.delete();
    #1;
    check_zero("midreset");
    @(posedge clk); #1;
    rst_n = 1;
    idle(1);
    send(4'b0011, 0, 2047, 5, 5, 1, 2047, 1, 0, 0);
    idle(1);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d results outstanding, required 0", sb.size());
    end
    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
